mod_counter: RTL
================

# mod_counter

Parametrised up/down counter, the successor to the team's fixed 16-bit loadable counter. It adds:
- configurable width;
- a programmable step size;
- a runtime upper limit (modulus);
- wrap or saturate behaviour at both ends;
- a terminal-count pulse and a sticky overflow/underflow flag.

It is used as a timing/event counter in datapath and controller blocks that need a non-power-of-two range.

## Interface

Parameters:
- WIDTH, 16, counter and limit width (≥ 2)
- STEP_W, 4, width of the step input (1 ≤ STEP_W ≤ WIDTH)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- ld_cnt  input  1  load request, active-low (0 = load data_in)
- data_in  input  WIDTH  load value
- count_enb  input  1  count enable, active-high
- updn_cnt  input  1  direction: 1 = up, 0 = down
- step  input  STEP_W  amount added/subtracted per enabled cycle, unsigned
- limit  input  WIDTH  maximum legal count; range is 0..limit inclusive
- sat_mode  input  1  1 = saturate at ends, 0 = wrap
- clr_flag  input  1  clears ovf, active-high
- data_out  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered, one cycle per boundary event
- ovf  output  1  sticky boundary-event flag, registered
- zero  output  1  combinational decode of data_out == 0

## Operation

- Reset values: data_out = 0, tc = 0, ovf = 0, so zero = 1. These hold while rst = 1, regardless of all other inputs.
- Priority per edge: rst > load (ld_cnt = 0) > count (count_enb = 1) > hold.
- Load:
  - data_out <= min(data_in, limit).
  - Clamping does not raise tc or ovf.
  - count_enb is ignored in the load cycle.
- Count, up (updn_cnt = 1): form sum = data_out + step in WIDTH+1 bits.
  - sum ≤ limit: data_out <= sum, no event.
  - sum > limit: boundary event. Wrap mode gives data_out <= 0; saturate mode gives data_out <= limit.
- Count, down (updn_cnt = 0):
  - step ≤ data_out: data_out <= data_out − step, no event.
  - step > data_out: boundary event. Wrap mode gives data_out <= limit; saturate mode gives data_out <= 0.
- Landing exactly on limit (up) or on 0 (down) is not an event.
- step = 0 with count_enb = 1: data_out unchanged, no event.
- Out-of-range state: if data_out > limit at a count edge (limit lowered at runtime), then data_out <= limit and a boundary event occurs, in either direction and either mode. With count_enb = 0 the out-of-range value is held unchanged.
- Saturated state: in saturate mode, a further count past an end holds the value and raises another event each enabled cycle.
- Boundary event:
  - tc = 1 for exactly the next cycle.
  - ovf set to 1.
- tc = 0 on every edge without an event, including load, hold and reset edges.
- ovf is cleared by clr_flag = 1. If an event and clr_flag occur on the same edge, set wins (ovf = 1).
- limit = 0: the counter stays at 0. Every enabled count with step ≥ 1 is a boundary event.

## Timing

- Single clock domain. No multicycle paths.
- data_out, tc and ovf update on the same rising edge that samples the inputs: one-cycle latency from input to output.
- zero is combinational from the data_out register, so it is valid in the same cycle as data_out.
- limit, step and sat_mode are sampled every edge. Changes take effect on the next edge, with no pipeline.
- Reset asserted mid-count overrides load and count on that edge. Counting resumes on the first edge after rst returns to 0.
- Critical path: WIDTH+1-bit add/subtract, compare against limit, then mux into data_out.

## Test plan

1. Reset: drive rst = 1 with ld_cnt = 0, data_in = 16'h1234, count_enb = 1. Required: data_out = 0, tc = 0, ovf = 0, zero = 1 on every edge while rst is high.
2. Wrap up: WIDTH = 16, limit = 9, step = 3, sat_mode = 0, load 0, count up.
   - Required sequence: 3, 6, 9, 0.
   - tc = 1 only in the cycle data_out becomes 0; ovf = 1 from then on.
   - clr_flag = 1 clears ovf on the next edge.
3. Saturate down: limit = 100, sat_mode = 1, load 5, step = 2, count down.
   - Required sequence: 3, 1, 0, 0.
   - tc = 1 on both cycles showing 0 (two events); ovf sticky.
4. Load clamp and priority: limit = 50. Load data_in = 200 with count_enb = 1 and updn_cnt = 1.
   - Required: data_out = 50, tc = 0, ovf = 0.
   - Next edge, up with step = 1 and sat_mode = 0: data_out = 0, tc = 1.
5. Runtime limit drop: count to 40 with limit = 63, then set limit = 20.
   - Hold (count_enb = 0): data_out stays 40.
   - Enable a down count with step = 1: data_out = 20, tc = 1, ovf = 1.
6. Corner cases: step = 0 with count_enb = 1 holds the value with tc = 0. Then limit = 0, step = 1, up, wrap mode: data_out stays 0 with tc = 1 every cycle. clr_flag asserted on an event edge leaves ovf = 1.

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down counter with programmable step, runtime
// modulus (limit), wrap/saturate ends, terminal-count pulse and sticky flag.
module mod_counter #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_cnt,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              count_enb,
   input  logic              updn_cnt,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
   input  logic              sat_mode,
   input  logic              clr_flag,
   output logic [WIDTH-1:0]  data_out,
   output logic              tc,
   output logic              ovf,
   output logic              zero
);

   localparam int unsigned EXT_W = WIDTH + 1;

   logic [WIDTH-1:0] cnt_nxt;
   logic             tc_nxt;
   logic             ovf_nxt;

   logic [EXT_W-1:0] sum_c;
   logic [EXT_W-1:0] lim_ext_c;
   logic [WIDTH-1:0] step_ext_c;
   logic             out_of_range_c;

   // Next-count, boundary event and flag computation.
   always_comb begin
      cnt_nxt        = data_out;
      tc_nxt         = 1'b0;
      ovf_nxt        = ovf;
      step_ext_c     = WIDTH'(step);
      sum_c          = EXT_W'(data_out) + EXT_W'(step);
      lim_ext_c      = EXT_W'(limit);
      out_of_range_c = (data_out > limit);

      if (!ld_cnt) begin
         // Loads are clamped into range silently.
         cnt_nxt = (data_in > limit) ? limit : data_in;
      end else if (count_enb) begin
         if (out_of_range_c) begin
            // Limit was lowered under us: pull back to limit as an event.
            cnt_nxt = limit;
            tc_nxt  = 1'b1;
         end else if (updn_cnt) begin
            if (sum_c > lim_ext_c) begin
               cnt_nxt = sat_mode ? limit : '0;
               tc_nxt  = 1'b1;
            end else begin
               cnt_nxt = WIDTH'(sum_c);
            end
         end else begin
            if (step_ext_c > data_out) begin
               cnt_nxt = sat_mode ? '0 : limit;
               tc_nxt  = 1'b1;
            end else begin
               cnt_nxt = data_out - step_ext_c;
            end
         end
      end

      // Event sets the flag and wins over a simultaneous clear.
      if (tc_nxt) begin
         ovf_nxt = 1'b1;
      end else if (clr_flag) begin
         ovf_nxt = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
         tc       <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         data_out <= cnt_nxt;
         tc       <= tc_nxt;
         ovf      <= ovf_nxt;
      end
   end

   // Zero decode straight off the count register.
   always_comb begin
      zero = (data_out == '0);
   end

endmodule
